// File: rtl/eth_rx_filter_if.sv
// Receive byte stream and FIFO write port for the Ethernet ingress filter.
interface eth_rx_filter_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_sof;
  logic       rx_eof;
  logic       fifo_full;
  logic       fifo_write;
  logic [7:0] fifo_data;
  logic       frame_done;

  modport master (
    output rx_valid, rx_data, rx_sof, rx_eof, fifo_full,
    input  fifo_write, fifo_data, frame_done
  );

  modport slave (
    input  rx_valid, rx_data, rx_sof, rx_eof, fifo_full,
    output fifo_write, fifo_data, frame_done
  );
endinterface

// File: rtl/eth_rx_filter.sv
// Ethernet ingress filter: destination MAC check, header strip, FIFO write with
// full handling, runt/oversize/overflow drop and saturating frame statistics.
module eth_rx_filter #(
  parameter logic [47:0] LOCAL_MAC    = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter int unsigned MAX_LEN      = 1518,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  eth_rx_filter_if.slave   bus,
  output logic [CNT_W-1:0] cnt_accept,
  output logic [CNT_W-1:0] cnt_drop,
  output logic [CNT_W-1:0] cnt_ovf
);

  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 2);
  localparam int unsigned HDR_LEN = 6;

  typedef enum logic [1:0] {IDLE, HDR, FWD, DROP} state_t;

  state_t           state;
  logic [LEN_W-1:0] byte_cnt;
  logic             match_local;
  logic             match_bcast;

  logic [LEN_W-1:0] byte_num_c;
  logic [7:0]       mac_byte_c;
  logic             local_ok_c;
  logic             bcast_ok_c;
  logic             accept_c;
  logic             oversize_c;
  logic [1:0]       sof_drop_c;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
    return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  endfunction

  // Position of the incoming byte in its frame and the running header match.
  always_comb begin
    byte_num_c = bus.rx_sof ? LEN_W'(1) : byte_cnt + LEN_W'(1);
    mac_byte_c = 8'h00;
    for (int unsigned k = 1; k <= HDR_LEN; k++) begin
      if (byte_num_c == LEN_W'(k)) mac_byte_c = LOCAL_MAC[8*(HDR_LEN-k) +: 8];
    end
    local_ok_c = (bus.rx_sof | match_local) & (bus.rx_data == mac_byte_c);
    bcast_ok_c = (bus.rx_sof | match_bcast) & (bus.rx_data == 8'hFF);
    accept_c   = local_ok_c | (bcast_ok_c & ACCEPT_BCAST);
    oversize_c = byte_num_c > LEN_W'(MAX_LEN);
    // An sof can end a live frame and be a 1-byte runt at once: two drops.
    sof_drop_c = {1'b0, (state == HDR) || (state == FWD)} + {1'b0, bus.rx_eof};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      match_local    <= 1'b1;
      match_bcast    <= 1'b1;
      bus.fifo_write <= 1'b0;
      bus.fifo_data  <= 8'h00;
      bus.frame_done <= 1'b0;
      cnt_accept     <= '0;
      cnt_drop       <= '0;
      cnt_ovf        <= '0;
    end else begin
      bus.fifo_write <= 1'b0;
      bus.frame_done <= 1'b0;
      if (bus.rx_valid) begin
        if (bus.rx_sof) begin
          cnt_drop    <= sat_add(cnt_drop, sof_drop_c);
          byte_cnt    <= LEN_W'(1);
          match_local <= local_ok_c;
          match_bcast <= bcast_ok_c;
          state       <= bus.rx_eof ? IDLE : HDR;
        end else begin
          case (state)
            HDR: begin
              byte_cnt    <= byte_num_c;
              match_local <= local_ok_c;
              match_bcast <= bcast_ok_c;
              if (oversize_c || bus.rx_eof) begin
                cnt_drop <= sat_add(cnt_drop, 2'd1);
                state    <= bus.rx_eof ? IDLE : DROP;
              end else if (byte_num_c == LEN_W'(HDR_LEN)) begin
                if (accept_c) begin
                  state <= FWD;
                end else begin
                  cnt_drop <= sat_add(cnt_drop, 2'd1);
                  state    <= DROP;
                end
              end
            end
            FWD: begin
              if (oversize_c) begin
                cnt_drop <= sat_add(cnt_drop, 2'd1);
                state    <= bus.rx_eof ? IDLE : DROP;
              end else if (bus.fifo_full) begin
                cnt_ovf <= sat_add(cnt_ovf, 2'd1);
                state   <= bus.rx_eof ? IDLE : DROP;
              end else begin
                bus.fifo_write <= 1'b1;
                bus.fifo_data  <= bus.rx_data;
                byte_cnt       <= byte_num_c;
                if (bus.rx_eof) begin
                  cnt_accept     <= sat_add(cnt_accept, 2'd1);
                  bus.frame_done <= 1'b1;
                  state          <= IDLE;
                end
              end
            end
            DROP: begin
              if (bus.rx_eof) state <= IDLE;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
